// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package regfile_sb_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   // INIT sweeps storage to zero; RUN serves normal traffic.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, marks an outstanding producer.
// A set and a clear on the same edge to the same entry leaves the bit set.
module regfile_sb_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] lk_addr_1,
   input  logic [AW-1:0] lk_addr_2,
   output logic          lk_busy_1,
   output logic          lk_busy_2
);

   logic [NREGS-1:0] busy_q;

   // Busy bits: cleared by reset, then clear-before-set so a new claim wins.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         if (clr_en) busy_q[clr_addr] <= 1'b0;
         if (set_en) busy_q[set_addr] <= 1'b1;
      end
   end

   assign lk_busy_1 = busy_q[lk_addr_1];
   assign lk_busy_2 = busy_q[lk_addr_2];

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a producer scoreboard.
// After reset an INIT sweep zeroes every entry, then RUN serves traffic
// with same-cycle write bypass on both data and busy lookups.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NREGS    = NREGS_DEF,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rd_addr_1,
   input  logic [AW-1:0]   rd_addr_2,
   output logic [XLEN-1:0] rd_data_1,
   output logic [XLEN-1:0] rd_data_2,
   output logic            rd_busy_1,
   output logic            rd_busy_2,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            claim_en,
   input  logic [AW-1:0]   claim_addr,
   output logic            ready
);

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            run;
   logic            wr_ok, claim_ok;
   logic            sb_clr_en;
   logic [AW-1:0]   sb_clr_addr;
   logic            lk_busy_1, lk_busy_2;
   logic [XLEN-1:0] mem [NREGS];

   // True when addr is the hardwired zero register.
   function automatic logic is_zero(input logic [AW-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // State and sweep counter; reset restarts the sweep from entry 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: INIT walks every entry once, then hands over to RUN.
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b0;
      unique case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            ready = 1'b1;
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign run      = (state_q == RUN);
   assign wr_ok    = run && wr_en    && !is_zero(wr_addr);
   assign claim_ok = run && claim_en && !is_zero(claim_addr);

   // Storage: INIT zeroes the swept entry, RUN takes the write port.
   // NOTE: the array has no reset; the INIT sweep is what clears it, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[cnt_q] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The sweep and RUN writes share the scoreboard's clear port.
   assign sb_clr_en   = !run || wr_ok;
   assign sb_clr_addr = run ? wr_addr : cnt_q;

   regfile_sb_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (claim_ok),
      .set_addr  (claim_addr),
      .clr_en    (sb_clr_en),
      .clr_addr  (sb_clr_addr),
      .lk_addr_1 (rd_addr_1),
      .lk_addr_2 (rd_addr_2),
      .lk_busy_1 (lk_busy_1),
      .lk_busy_2 (lk_busy_2)
   );

   // Read ports: zero outside RUN and for the zero register, else bypass or storage.
   always_comb begin
      rd_data_1 = '0;
      rd_data_2 = '0;
      rd_busy_1 = 1'b0;
      rd_busy_2 = 1'b0;
      if (run) begin
         if (!is_zero(rd_addr_1)) begin
            rd_data_1 = (wr_ok && wr_addr == rd_addr_1) ? wr_data : mem[rd_addr_1];
            rd_busy_1 = lk_busy_1 && !(wr_ok && wr_addr == rd_addr_1);
         end
         if (!is_zero(rd_addr_2)) begin
            rd_data_2 = (wr_ok && wr_addr == rd_addr_2) ? wr_data : mem[rd_addr_2];
            rd_busy_2 = lk_busy_2 && !(wr_ok && wr_addr == rd_addr_2);
         end
      end
   end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_REG = 1 and 0) share stimulus;
// a behavioural model is compared on every negative clock edge, and
// directed steps pin hand-computed values.
module tb_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   rd_addr_1, rd_addr_2, wr_addr, claim_addr;
   logic            wr_en, claim_en;
   logic [XLEN-1:0] wr_data;

   logic [XLEN-1:0] rd_data_1 [2];
   logic [XLEN-1:0] rd_data_2 [2];
   logic            rd_busy_1 [2];
   logic            rd_busy_2 [2];
   logic            ready     [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) u_dut_z (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
      .rd_data_1(rd_data_1[0]), .rd_data_2(rd_data_2[0]),
      .rd_busy_1(rd_busy_1[0]), .rd_busy_2(rd_busy_2[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .ready(ready[0])
   );

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
      .rd_data_1(rd_data_1[1]), .rd_data_2(rd_data_2[1]),
      .rd_busy_1(rd_busy_1[1]), .rd_busy_2(rd_busy_2[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .ready(ready[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Edges seen since reset released; the first NREGS edges are the sweep.
   int              m_edges = 0;
   logic [XLEN-1:0] m_mem  [2][NREGS];
   bit              m_busy [2][NREGS];

   function automatic bit zr(input int i);
      return (i == 0);
   endfunction

   function automatic bit m_ready();
      return (m_edges >= NREGS);
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input int i, input logic [AW-1:0] a);
      if (!m_ready())                 return '0;
      if (zr(i) && a == 0)            return '0;
      if (wr_en && wr_addr == a)      return wr_data;
      return m_mem[i][a];
   endfunction

   function automatic bit exp_busy(input int i, input logic [AW-1:0] a);
      if (!m_ready())                 return 1'b0;
      if (zr(i) && a == 0)            return 1'b0;
      return m_busy[i][a] && !(wr_en && wr_addr == a);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges <= 0;
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < NREGS; a++) m_busy[i][a] <= 1'b0;
      end else if (m_edges < NREGS) begin
         for (int i = 0; i < 2; i++) begin
            m_mem[i][m_edges]  <= '0;
            m_busy[i][m_edges] <= 1'b0;
         end
         m_edges <= m_edges + 1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr_en && !(zr(i) && wr_addr == 0)) begin
               m_mem[i][wr_addr]  <= wr_data;
               m_busy[i][wr_addr] <= 1'b0;
            end
            if (claim_en && !(zr(i) && claim_addr == 0))
               m_busy[i][claim_addr] <= 1'b1;
         end
      end
   end

   // Compare every output of both instances against the model each cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check($sformatf("cmp_ready[%0d]", i),     64'(ready[i]),     64'(m_ready()));
         check($sformatf("cmp_rd_data_1[%0d]", i), 64'(rd_data_1[i]), 64'(exp_data(i, rd_addr_1)));
         check($sformatf("cmp_rd_data_2[%0d]", i), 64'(rd_data_2[i]), 64'(exp_data(i, rd_addr_2)));
         check($sformatf("cmp_rd_busy_1[%0d]", i), 64'(rd_busy_1[i]), 64'(exp_busy(i, rd_addr_1)));
         check($sformatf("cmp_rd_busy_2[%0d]", i), 64'(rd_busy_2[i]), 64'(exp_busy(i, rd_addr_2)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      claim_en = 1'b0;
   endtask

   // Release reset and check ready rises exactly NREGS edges later.
   task automatic release_and_sweep(input string tag, input bit poke_init);
      rst_n = 1'b1;
      for (int k = 1; k <= NREGS; k++) begin
         cyc();
         if (poke_init) begin
            // Writes/claims during INIT must be dropped.
            wr_en      = (k >= 8 && k < NREGS);
            wr_addr    = 5'd4;
            wr_data    = 32'h5555;
            claim_en   = (k >= 8 && k < NREGS);
            claim_addr = 5'd6;
         end
         #1;
         check($sformatf("%s_ready_k%0d_z", tag, k),  64'(ready[0]), 64'(k == NREGS));
         check($sformatf("%s_ready_k%0d_nz", tag, k), 64'(ready[1]), 64'(k == NREGS));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      rd_addr_1 = '0; rd_addr_2 = '0; wr_addr = '0; claim_addr = '0;
      wr_data = '0; wr_en = 1'b0; claim_en = 1'b0;
      #2 rst_n = 1'b0;

      // Reset state.
      repeat (3) cyc();
      #1;
      check("rst_ready", 64'(ready[0]), 64'd0);
      check("rst_data1", 64'(rd_data_1[0]), 64'd0);

      // Sweep, then every entry reads zero and idle.
      release_and_sweep("sweep1", 1'b0);
      for (int a = 0; a < NREGS; a++) begin
         cyc();
         rd_addr_1 = AW'(a);
         rd_addr_2 = AW'(NREGS - 1 - a);
         #1;
         check($sformatf("init_zero_%0d", a), 64'(rd_data_1[1]), 64'd0);
         check($sformatf("init_idle_%0d", a), 64'(rd_busy_1[1]), 64'd0);
      end

      // Write bypass then storage read.
      cyc(); wr_en = 1; wr_addr = 5'd2; wr_data = 32'h35A4; rd_addr_1 = 5'd2; #1;
      check("bypass_e2", 64'(rd_data_1[0]), 64'h35A4);
      cyc(); idle(); #1;
      check("stored_e2", 64'(rd_data_1[0]), 64'h35A4);

      // Claim then write: busy visible next cycle, cleared by same-cycle write.
      cyc(); claim_en = 1; claim_addr = 5'd5; rd_addr_2 = 5'd5; #1;
      check("claim_e5_same", 64'(rd_busy_2[0]), 64'd0);
      cyc(); idle(); #1;
      check("claim_e5_next", 64'(rd_busy_2[0]), 64'd1);
      cyc(); wr_en = 1; wr_addr = 5'd5; wr_data = 32'h10; #1;
      check("wr_e5_busy", 64'(rd_busy_2[0]), 64'd0);
      check("wr_e5_data", 64'(rd_data_2[0]), 64'h10);
      cyc(); idle(); #1;
      check("after_e5_busy", 64'(rd_busy_2[1]), 64'd0);
      check("after_e5_data", 64'(rd_data_2[1]), 64'h10);

      // Claim and write same entry on the same edge: new producer wins.
      cyc(); wr_en = 1; wr_addr = 5'd3; wr_data = 32'h11AB0;
      claim_en = 1; claim_addr = 5'd3; rd_addr_1 = 5'd3; #1;
      check("cw_e3_bypass", 64'(rd_data_1[0]), 64'h11AB0);
      check("cw_e3_busy_now", 64'(rd_busy_1[0]), 64'd0);
      cyc(); idle(); #1;
      check("cw_e3_data", 64'(rd_data_1[0]), 64'h11AB0);
      check("cw_e3_busy", 64'(rd_busy_1[0]), 64'd1);

      // Claim and write different entries on the same edge.
      cyc(); wr_en = 1; wr_addr = 5'd10; wr_data = 32'h777;
      claim_en = 1; claim_addr = 5'd9; #1;
      cyc(); idle(); rd_addr_1 = 5'd9; rd_addr_2 = 5'd10; #1;
      check("split_e9_busy", 64'(rd_busy_1[0]), 64'd1);
      check("split_e10_data", 64'(rd_data_2[0]), 64'h777);
      check("split_e10_busy", 64'(rd_busy_2[0]), 64'd0);

      // Zero register: dropped with ZERO_REG=1, stored with ZERO_REG=0.
      cyc(); wr_en = 1; wr_addr = 5'd0; wr_data = 32'h2B124E;
      claim_en = 1; claim_addr = 5'd0; rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; #1;
      check("zr_bypass_z",  64'(rd_data_1[0]), 64'd0);
      check("zr_bypass_nz", 64'(rd_data_1[1]), 64'h2B124E);
      cyc(); idle(); #1;
      check("zr_data_z",  64'(rd_data_2[0]), 64'd0);
      check("zr_busy_z",  64'(rd_busy_2[0]), 64'd0);
      check("zr_data_nz", 64'(rd_data_2[1]), 64'h2B124E);
      check("zr_busy_nz", 64'(rd_busy_2[1]), 64'd1);

      // Mixed traffic checked by the model.
      for (int n = 0; n < 60; n++) begin
         cyc();
         wr_en      = 1'($urandom_range(0, 1));
         wr_addr    = AW'($urandom_range(0, 7));
         wr_data    = $urandom;
         claim_en   = 1'($urandom_range(0, 1));
         claim_addr = AW'($urandom_range(0, 7));
         rd_addr_1  = AW'($urandom_range(0, 7));
         rd_addr_2  = AW'($urandom_range(0, 7));
      end
      cyc(); idle();

      // Reset mid-sweep after a RUN write to entry 7.
      cyc(); wr_en = 1; wr_addr = 5'd7; wr_data = 32'hDEAD; #1;
      cyc(); idle(); rd_addr_1 = 5'd7; #1;
      check("pre_rst_e7", 64'(rd_data_1[0]), 64'hDEAD);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      repeat (10) cyc();
      rst_n = 1'b0;
      #1;
      check("midinit_ready", 64'(ready[0]), 64'd0);
      repeat (2) cyc();
      release_and_sweep("sweep2", 1'b1);
      idle();
      rd_addr_1 = 5'd7; rd_addr_2 = 5'd4; #1;
      check("post_e7_z",  64'(rd_data_1[0]), 64'd0);
      check("post_e7_nz", 64'(rd_data_1[1]), 64'd0);
      check("post_e4",    64'(rd_data_2[0]), 64'd0);
      cyc(); rd_addr_2 = 5'd6; #1;
      check("post_e6_busy", 64'(rd_busy_2[0]), 64'd0);
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_regfile_sb
